// File: rtl/psram_burst_drainer_if.sv
// Bundles the FIFO read side and the PSRAM write handshake of the burst drainer.
// The master modport is the drainer; the slave modport is its environment.
interface psram_burst_drainer_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned ADDR_WIDTH = 21
);
    logic                            fifo_rd_en;
    logic [DATA_WIDTH-1:0]           fifo_data;
    logic                            fifo_empty;
    logic                            fifo_half;
    logic                            wr_valid;
    logic                            wr_ready;
    logic [DATA_WIDTH*BURST_LEN-1:0] wr_data;
    logic [ADDR_WIDTH-1:0]           wr_addr;

    modport master (
        output fifo_rd_en,
        input  fifo_data,
        input  fifo_empty,
        input  fifo_half,
        output wr_valid,
        input  wr_ready,
        output wr_data,
        output wr_addr
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_data,
        output fifo_empty,
        output fifo_half,
        input  wr_valid,
        output wr_ready,
        input  wr_data,
        input  wr_addr
    );
endinterface

// File: rtl/psram_burst_drainer.sv
// Drains 16-bit samples from the ADC FIFO, packs BURST_LEN of them into one word and hands each
// word with a linear byte address to the PSRAM write controller. A flush drains the FIFO tail one
// sample at a time, zero-pads the last partial word, writes it and then raises a sticky done.
module psram_burst_drainer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned ADDR_WIDTH = 21,
    parameter int unsigned ADDR_LIMIT = 2 ** 21,
    parameter bit          WRAP       = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flush,
    psram_burst_drainer_if.master bus,
    output logic                  done,
    output logic [7:0]            wrap_cnt
);

    localparam int unsigned STEP   = BURST_LEN * DATA_WIDTH / 8;
    localparam int unsigned LANE_W = $clog2(BURST_LEN + 1);
    localparam int unsigned CNT_W  = (LANE_W < 2) ? 2 : LANE_W;

    typedef enum logic [2:0] {StIdle, StBurst, StCapt, StSingle, StWrite} state_e;

    state_e                                 state_q, state_d;
    logic [LANE_W-1:0]                      lane_q, lane_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic [BURST_LEN-1:0][DATA_WIDTH-1:0]   pack_q, pack_d;
    logic [ADDR_WIDTH-1:0]                  addr_q, addr_d;
    logic                                   done_q, done_d;
    logic [7:0]                             wrap_cnt_q, wrap_cnt_d;
    logic                                   flush_pending_q, flush_pending_d;
    logic                                   rd_q, rd_d;
    logic                                   rd_en;
    logic                                   wr_valid;
    logic [31:0]                            addr_sum;

    // Next-state, capture path and Moore outputs; nothing here looks at wr_ready except next-state.
    always_comb begin
        state_d         = state_q;
        lane_d          = lane_q;
        cnt_d           = cnt_q;
        pack_d          = pack_q;
        addr_d          = addr_q;
        done_d          = done_q;
        wrap_cnt_d      = wrap_cnt_q;
        flush_pending_d = flush_pending_q | flush;
        rd_en           = 1'b0;
        wr_valid        = 1'b0;
        addr_sum        = 32'(addr_q) + 32'(STEP);

        // FIFO data is valid the cycle after a strobe, whatever state we are in by then.
        if (rd_q) begin
            for (int unsigned i = 0; i < BURST_LEN; i++) begin
                if (lane_q == LANE_W'(i)) begin
                    pack_d[i] = bus.fifo_data;
                end
            end
            if (lane_q < LANE_W'(BURST_LEN)) begin
                lane_d = lane_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (done_q) begin
                    state_d = StIdle;
                end else if (enable && bus.fifo_half) begin
                    state_d = StBurst;
                end else if (flush_pending_q && !bus.fifo_empty) begin
                    state_d = StSingle;
                end else if (flush_pending_q && (lane_q != '0)) begin
                    // Unfilled lanes are already zero since the pack register clears on write.
                    state_d = StWrite;
                end else if (flush_pending_q) begin
                    done_d = 1'b1;
                end
            end
            StBurst: begin
                rd_en = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                    state_d = StCapt;
                end
            end
            StCapt: begin
                state_d = StWrite;
            end
            StSingle: begin
                // Phase 0 strobes, phase 1 captures, phase 2 lets the registered empty flag settle.
                rd_en = (cnt_q == '0);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(2)) begin
                    cnt_d   = '0;
                    state_d = (lane_q == LANE_W'(BURST_LEN)) ? StWrite : StIdle;
                end
            end
            StWrite: begin
                wr_valid = 1'b1;
                if (bus.wr_ready) begin
                    lane_d  = '0;
                    pack_d  = '0;
                    state_d = StIdle;
                    if (addr_sum >= ADDR_LIMIT) begin
                        if (WRAP) begin
                            addr_d = '0;
                            if (wrap_cnt_q != 8'hFF) begin
                                wrap_cnt_d = wrap_cnt_q + 8'd1;
                            end
                        end else begin
                            addr_d = ADDR_WIDTH'(addr_sum);
                            done_d = 1'b1;
                        end
                    end else begin
                        addr_d = ADDR_WIDTH'(addr_sum);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        rd_d = rd_en;
    end

    // State and datapath registers; reset overrides any in-flight read or pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            lane_q          <= '0;
            cnt_q           <= '0;
            pack_q          <= '0;
            addr_q          <= '0;
            done_q          <= 1'b0;
            wrap_cnt_q      <= 8'd0;
            flush_pending_q <= 1'b0;
            rd_q            <= 1'b0;
        end else begin
            state_q         <= state_d;
            lane_q          <= lane_d;
            cnt_q           <= cnt_d;
            pack_q          <= pack_d;
            addr_q          <= addr_d;
            done_q          <= done_d;
            wrap_cnt_q      <= wrap_cnt_d;
            flush_pending_q <= flush_pending_d;
            rd_q            <= rd_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.wr_valid   = wr_valid;
    assign bus.wr_data    = pack_q;
    assign bus.wr_addr    = addr_q;
    assign done           = done_q;
    assign wrap_cnt       = wrap_cnt_q;

endmodule

// File: tb/tb_psram_burst_drainer.sv
// Bench for psram_burst_drainer. Instance A wraps at a 16-byte limit and is driven with a long
// randomized sample stream scored against a stream-level model; instance B stops at the same limit.
module tb_psram_burst_drainer;

    localparam int DW     = 16;
    localparam int BL     = 4;
    localparam int AW     = 21;
    localparam int FDEPTH = 8;

    typedef struct packed {
        logic [63:0]   data;
        logic [AW-1:0] addr;
        logic [7:0]    wraps;
        logic [7:0]    nsamp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable_a = 1'b0, flush_a = 1'b0, done_a;
    logic       enable_b = 1'b0, flush_b = 1'b0, done_b;
    logic [7:0] wrap_a, wrap_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psram_burst_drainer_if #(.DATA_WIDTH(DW), .BURST_LEN(BL), .ADDR_WIDTH(AW)) bus_a ();
    psram_burst_drainer_if #(.DATA_WIDTH(DW), .BURST_LEN(BL), .ADDR_WIDTH(AW)) bus_b ();

    psram_burst_drainer #(
        .DATA_WIDTH(DW), .BURST_LEN(BL), .ADDR_WIDTH(AW), .ADDR_LIMIT(16), .WRAP(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .enable(enable_a), .flush(flush_a),
        .bus(bus_a.master), .done(done_a), .wrap_cnt(wrap_a)
    );

    psram_burst_drainer #(
        .DATA_WIDTH(DW), .BURST_LEN(BL), .ADDR_WIDTH(AW), .ADDR_LIMIT(16), .WRAP(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable_b), .flush(flush_b),
        .bus(bus_b.master), .done(done_b), .wrap_cnt(wrap_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // ---------------- FIFO models: registered data, empty lags the count by one edge ----------
    logic [DW-1:0] src_a[$], fifo_a[$], src_b[$], fifo_b[$];

    always @(posedge clk) begin
        int old;
        old = fifo_a.size();
        if (reset) begin
            fifo_a.delete();
            bus_a.fifo_data  <= '0;
            bus_a.fifo_empty <= 1'b1;
            bus_a.fifo_half  <= 1'b0;
        end else begin
            if (bus_a.fifo_rd_en && fifo_a.size() > 0) bus_a.fifo_data <= fifo_a.pop_front();
            if (src_a.size() > 0 && fifo_a.size() < FDEPTH) fifo_a.push_back(src_a.pop_front());
            bus_a.fifo_empty <= (old == 0);
            bus_a.fifo_half  <= (fifo_a.size() > FDEPTH / 2);
        end
    end

    always @(posedge clk) begin
        int old;
        old = fifo_b.size();
        if (reset) begin
            fifo_b.delete();
            bus_b.fifo_data  <= '0;
            bus_b.fifo_empty <= 1'b1;
            bus_b.fifo_half  <= 1'b0;
        end else begin
            if (bus_b.fifo_rd_en && fifo_b.size() > 0) bus_b.fifo_data <= fifo_b.pop_front();
            if (src_b.size() > 0 && fifo_b.size() < FDEPTH) fifo_b.push_back(src_b.pop_front());
            bus_b.fifo_empty <= (old == 0);
            bus_b.fifo_half  <= (fifo_b.size() > FDEPTH / 2);
        end
    end

    // ---------------- wr_ready drivers: 0 = always ready, 1 = random, 2 = stalled --------------
    int rdy_mode = 0;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus_a.wr_ready = 1'b1;
            1:       bus_a.wr_ready = 1'($urandom_range(0, 1));
            default: bus_a.wr_ready = 1'b0;
        endcase
    end

    initial bus_b.wr_ready = 1'b1;

    // ---------------- Reference model for A: samples grouped in order into words -------------
    exp_t          exp_q[$];
    logic [DW-1:0] acc[$];
    int            words_issued = 0;

    task automatic emit_word();
        exp_t e;
        int   n;
        n       = acc.size();
        e.data  = '0;
        e.nsamp = 8'(n);
        for (int i = 0; i < n; i++) e.data[16*i +: 16] = acc[i];
        e.addr  = AW'((words_issued * 8) % 16);
        e.wraps = (words_issued / 2 > 255) ? 8'd255 : 8'(words_issued / 2);
        exp_q.push_back(e);
        acc.delete();
        words_issued++;
    endtask

    task automatic push_sample(input logic [DW-1:0] s);
        src_a.push_back(s);
        acc.push_back(s);
        if (acc.size() == BL) emit_word();
    endtask

    task automatic wait_exp(input int left, input int budget, input string name);
        int n = 0;
        while (exp_q.size() > left && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'(left));
    endtask

    // ---------------- Monitor A: scoreboard, hold stability, read accounting -----------------
    int            rd_cnt_a = 0;
    bit            held = 1'b0;
    logic [63:0]   held_data;
    logic [AW-1:0] held_addr;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            rd_cnt_a = 0;
            held     = 1'b0;
        end else begin
            if (bus_a.fifo_rd_en) begin
                chk("a_rd_while_empty", 64'(fifo_a.size() > 0), 64'd1);
                rd_cnt_a++;
            end
            if (bus_a.wr_valid) begin
                if (held) begin
                    chk("a_hold_data", bus_a.wr_data, held_data);
                    chk("a_hold_addr", 64'(bus_a.wr_addr), 64'(held_addr));
                end
                if (bus_a.wr_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("a_unexpected_word", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("a_data", bus_a.wr_data, e.data);
                        chk("a_addr", 64'(bus_a.wr_addr), 64'(e.addr));
                        chk("a_wrap_cnt", 64'(wrap_a), 64'(e.wraps));
                        chk("a_rd_per_word", 64'(rd_cnt_a), 64'(e.nsamp));
                    end
                    rd_cnt_a = 0;
                    held     = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_data = bus_a.wr_data;
                    held_addr = bus_a.wr_addr;
                end
            end
        end
    end

    // ---------------- Monitor B: two words then stop -------------------------------------------
    logic [DW-1:0] bsamp[16];
    int            words_b = 0;
    int            rd_b_after_done = 0;

    always @(negedge clk) begin
        logic [63:0] w;
        if (!reset) begin
            if (bus_b.fifo_rd_en && done_b) rd_b_after_done++;
            if (bus_b.wr_valid && bus_b.wr_ready) begin
                if (words_b < 4) begin
                    w = {bsamp[4*words_b+3], bsamp[4*words_b+2], bsamp[4*words_b+1], bsamp[4*words_b]};
                    chk("b_data", bus_b.wr_data, w);
                    chk("b_addr", 64'(bus_b.wr_addr), 64'(8 * words_b));
                end
                words_b++;
            end
        end
    end

    // ---------------- Stimulus ----------------------------------------------------------------
    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", 64'(bus_a.fifo_rd_en), 64'd0);
        chk("rst_wr_valid", 64'(bus_a.wr_valid), 64'd0);
        chk("rst_wr_data", bus_a.wr_data, 64'd0);
        chk("rst_wr_addr", 64'(bus_a.wr_addr), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_wrap_cnt", 64'(wrap_a), 64'd0);
        reset = 1'b0;

        // Reset in the middle of a burst.
        for (int i = 0; i < 8; i++) src_a.push_back(16'(16'h0100 + i));
        enable_a = 1'b1;
        n = 0;
        while (!bus_a.fifo_rd_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t1_burst_started", 64'(bus_a.fifo_rd_en), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        src_a.delete();
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        enable_a = 1'b0;
        chk("t1_rd_en", 64'(bus_a.fifo_rd_en), 64'd0);
        chk("t1_wr_valid", 64'(bus_a.wr_valid), 64'd0);
        chk("t1_wr_data", bus_a.wr_data, 64'd0);
        chk("t1_wr_addr", 64'(bus_a.wr_addr), 64'd0);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_a.fifo_rd_en) n++;
        end
        chk("t1_no_rd_after_reset", 64'(n), 64'd0);

        // Ordered burst stream; the last word stays in the FIFO below the half mark.
        enable_a = 1'b1;
        for (int i = 1; i <= 64; i++) push_sample(16'(i));
        wait_exp(1, 2000, "t2_drain");

        // Backpressure: ten stalled cycles while a word is presented.
        rdy_mode = 2;
        for (int i = 0; i < 4; i++) push_sample(16'(16'h0200 + i));
        n = 0;
        while (!bus_a.wr_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t3_valid_seen", 64'(bus_a.wr_valid), 64'd1);
        repeat (10) @(negedge clk);
        chk("t3_still_valid", 64'(bus_a.wr_valid), 64'd1);
        rdy_mode = 0;
        wait_exp(1, 200, "t3_drain");

        // Random stream, random ready, enable toggling; long enough to saturate wrap_cnt.
        rdy_mode = 1;
        for (int i = 0; i < 2048; i++) begin
            push_sample(16'($urandom));
            if ($urandom_range(0, 15) == 0) enable_a = ~enable_a;
            @(negedge clk);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        enable_a = 1'b1;
        rdy_mode = 0;
        wait_exp(1, 30000, "rand_drain");
        chk("rand_wrap_saturated", 64'(wrap_a), 64'd255);

        // Flush tail: six samples, one full word then a zero-padded pair.
        for (int i = 1; i <= 6; i++) push_sample(16'(16'h00A0 + i));
        wait_exp(0, 500, "t4_bursts");
        repeat (10) @(negedge clk);
        chk("t4_done_before_flush", 64'(done_a), 64'd0);
        flush_a = 1'b1;
        @(negedge clk);
        flush_a = 1'b0;
        if (acc.size() > 0) emit_word();
        wait_exp(0, 500, "t4_tail_word");
        n = 0;
        while (!done_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_done", 64'(done_a), 64'd1);
        for (int i = 0; i < 8; i++) src_a.push_back(16'(16'h0300 + i));
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus_a.fifo_rd_en || bus_a.wr_valid) n++;
        end
        chk("t4_quiet_after_done", 64'(n), 64'd0);

        // Instance B: no wrap, stops after the second word.
        for (int i = 0; i < 16; i++) begin
            bsamp[i] = 16'($urandom);
            src_b.push_back(bsamp[i]);
        end
        enable_b = 1'b1;
        repeat (300) @(negedge clk);
        chk("t5_words", 64'(words_b), 64'd2);
        chk("t5_done", 64'(done_b), 64'd1);
        chk("t5_wrap_cnt", 64'(wrap_b), 64'd0);
        chk("t5_rd_after_done", 64'(rd_b_after_done), 64'd0);
        chk("t5_no_valid", 64'(bus_b.wr_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
